// File: rtl/cbs_pkg.sv
// Shared definitions for the credit-based shaper scheduler: class sizing,
// FSM state encoding and the saturating credit arithmetic helper.
package cbs_pkg;

    localparam int unsigned NUM_CLASSES = 4;
    localparam int unsigned CLASS_W     = 2;

    typedef enum logic [0:0] {
        IDLE,
        XFER
    } state_t;

    // Signed a + b, clamped to the range of a w-bit two's complement value.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cbs_credit_counter.sv
// Per-class credit counter: loses send_slope per sent byte, gains idle_slope
// per cycle while traffic waits (ceiling hi_credit), clears when idle.
module cbs_credit_counter
    import cbs_pkg::*;
#(
    parameter int CREDIT_W = 24,
    parameter int SLOPE_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sending,
    input  logic                       pending,
    input  logic [SLOPE_W-1:0]         idle_slope,
    input  logic [SLOPE_W-1:0]         send_slope,
    input  logic [CREDIT_W-1:0]        hi_credit,
    output logic signed [CREDIT_W-1:0] credit,
    output logic                       eligible_ok
);

    logic signed [CREDIT_W:0]   cred_x;
    logic signed [CREDIT_W:0]   idle_x;
    logic signed [CREDIT_W:0]   send_x;
    logic signed [CREDIT_W:0]   hi_x;
    logic signed [CREDIT_W:0]   inc_x;
    logic signed [CREDIT_W:0]   inc_min;
    logic signed [CREDIT_W-1:0] dec_sat;
    logic signed [CREDIT_W-1:0] inc_sat;

    // One guard bit keeps the intermediate add/sub exact before clamping.
    assign cred_x  = {credit[CREDIT_W-1], credit};
    assign idle_x  = {{(CREDIT_W + 1 - SLOPE_W){1'b0}}, idle_slope};
    assign send_x  = {{(CREDIT_W + 1 - SLOPE_W){1'b0}}, send_slope};
    assign hi_x    = {hi_credit[CREDIT_W-1], hi_credit};
    assign inc_x   = cred_x + idle_x;
    assign inc_min = (inc_x > hi_x) ? hi_x : inc_x;

    always_comb begin
        dec_sat = CREDIT_W'(sat_add(64'(cred_x), -64'(send_x), CREDIT_W));
        inc_sat = CREDIT_W'(sat_add(64'(inc_min), 64'sd0, CREDIT_W));
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            credit <= '0;
        end else if (sending) begin
            credit <= dec_sat;
        end else if (pending || credit[CREDIT_W-1]) begin
            credit <= inc_sat;
        end else begin
            credit <= '0;
        end
    end

    assign eligible_ok = !en || !credit[CREDIT_W-1];

endmodule

// File: rtl/cbs_scheduler.sv
// Credit-based shaper scheduler: strict-priority arbitration of four byte-wide
// class streams gated by per-class credit. Frame counters built only with CBS_STATS_EN.
module cbs_scheduler
    import cbs_pkg::*;
#(
    parameter int CREDIT_W = 24,
    parameter int SLOPE_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   s_axis_tdata,
    input  logic [3:0]                    s_axis_tvalid,
    output logic [3:0]                    s_axis_tready,
    input  logic [3:0]                    s_axis_tlast,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [1:0]                    m_axis_tuser,
    input  logic [3:0]                    cbs_en,
    input  logic [4*SLOPE_W-1:0]          idle_slope,
    input  logic [4*SLOPE_W-1:0]          send_slope,
    input  logic [4*CREDIT_W-1:0]         hi_credit,
    output logic [4*CREDIT_W-1:0]         credit,
    output logic [4*32-1:0]               frame_cnt
);

    state_t                 state;
    logic [CLASS_W-1:0]     grant;
    logic [CLASS_W-1:0]     winner;
    logic [NUM_CLASSES-1:0] eligible_ok;
    logic [NUM_CLASSES-1:0] eligible;
    logic [NUM_CLASSES-1:0] sending;
    logic                   frame_done;

    assign eligible = s_axis_tvalid & eligible_ok;

    // Ascending scan so the highest eligible index wins.
    always_comb begin
        winner = '0;
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            if (eligible[c]) begin
                winner = CLASS_W'(c);
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        if (state == XFER) begin
            m_axis_tdata         = s_axis_tdata[8*grant +: 8];
            m_axis_tvalid        = s_axis_tvalid[grant];
            m_axis_tlast         = s_axis_tlast[grant];
            m_axis_tuser         = grant;
            s_axis_tready[grant] = m_axis_tready;
        end
    end

    assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        grant <= winner;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (frame_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
        assign sending[c] = (state == XFER) && (grant == CLASS_W'(c)) &&
                            s_axis_tvalid[c] && m_axis_tready;

        cbs_credit_counter #(
            .CREDIT_W(CREDIT_W),
            .SLOPE_W (SLOPE_W)
        ) u_credit (
            .clk        (clk),
            .rst        (rst),
            .en         (cbs_en[c]),
            .sending    (sending[c]),
            .pending    (s_axis_tvalid[c]),
            .idle_slope (idle_slope[c*SLOPE_W +: SLOPE_W]),
            .send_slope (send_slope[c*SLOPE_W +: SLOPE_W]),
            .hi_credit  (hi_credit[c*CREDIT_W +: CREDIT_W]),
            .credit     (credit[c*CREDIT_W +: CREDIT_W]),
            .eligible_ok(eligible_ok[c])
        );
    end

`ifdef CBS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                if (grant == CLASS_W'(c)) begin
                    frame_cnt[c*32 +: 32] <= frame_cnt[c*32 +: 32] + 32'd1;
                end
            end
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cbs_scheduler.sv
// Directed bench for cbs_scheduler: vector table for arbitration/stall/reset,
// hand sequences for credit gating, hi_credit clamp, backpressure and stats.
module tb_cbs_scheduler;

    localparam int CW = 24;
    localparam int SW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      s_axis_tdata;
    logic [3:0]       s_axis_tvalid;
    logic [3:0]       s_axis_tready;
    logic [3:0]       s_axis_tlast;
    logic [7:0]       m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [1:0]       m_axis_tuser;
    logic [3:0]       cbs_en;
    logic [4*SW-1:0]  idle_slope;
    logic [4*SW-1:0]  send_slope;
    logic [4*CW-1:0]  hi_credit;
    logic [4*CW-1:0]  credit;
    logic [4*32-1:0]  frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    cbs_scheduler #(.CREDIT_W(CW), .SLOPE_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .cbs_en       (cbs_en),
        .idle_slope   (idle_slope),
        .send_slope   (send_slope),
        .hi_credit    (hi_credit),
        .credit       (credit),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        mr;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [1:0]  eu;
        logic [3:0]  esr;
    } vec_t;

    vec_t tbl [26];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic signed [CW-1:0] cr(input int c);
        return credit[c*CW +: CW];
    endfunction

    task automatic clear_inputs();
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        cbs_en        = '0;
        idle_slope    = '0;
        send_slope    = '0;
        hi_credit     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    // Unshaped single-class frame: one IDLE cycle then len bytes, tready held high.
    task automatic send_frame(input int cls, input int len);
        s_axis_tvalid = 4'(1 << cls);
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        settle();
        chk($sformatf("sf%0d_idle_valid", cls), 64'(m_axis_tvalid), 64'd0);
        cyc();
        for (int b = 0; b < len; b++) begin
            s_axis_tdata = '0;
            s_axis_tdata[cls*8 +: 8] = 8'(cls * 16 + b);
            s_axis_tlast = (b == len - 1) ? 4'(1 << cls) : 4'd0;
            settle();
            chk($sformatf("sf%0d_b%0d_user", cls, b), 64'(m_axis_tuser), 64'(cls));
            chk($sformatf("sf%0d_b%0d_data", cls, b), 64'(m_axis_tdata), 64'(cls * 16 + b));
            cyc();
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    initial begin
        int idx;
        int k;
        logic [31:0] exp_cnt [4];

        // rst, tv, tl, td, mr, ev, ed, el, eu, esr
        tbl[0]  = '{1'b1, 4'hF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[3]  = '{1'b0, 4'hA, 4'h0, 32'h30001000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[4]  = '{1'b0, 4'hA, 4'h0, 32'h30001000, 1'b1, 1'b1, 8'h30, 1'b0, 2'd3, 4'h8};
        tbl[5]  = '{1'b0, 4'hA, 4'h0, 32'h31001000, 1'b1, 1'b1, 8'h31, 1'b0, 2'd3, 4'h8};
        tbl[6]  = '{1'b0, 4'hA, 4'h0, 32'h32001000, 1'b1, 1'b1, 8'h32, 1'b0, 2'd3, 4'h8};
        tbl[7]  = '{1'b0, 4'hA, 4'h8, 32'h33001000, 1'b1, 1'b1, 8'h33, 1'b1, 2'd3, 4'h8};
        tbl[8]  = '{1'b0, 4'h2, 4'h0, 32'h00001000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[9]  = '{1'b0, 4'h2, 4'h0, 32'h00001000, 1'b1, 1'b1, 8'h10, 1'b0, 2'd1, 4'h2};
        tbl[10] = '{1'b0, 4'h2, 4'h0, 32'h00001100, 1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 4'h2};
        tbl[11] = '{1'b0, 4'h2, 4'h0, 32'h00001200, 1'b1, 1'b1, 8'h12, 1'b0, 2'd1, 4'h2};
        tbl[12] = '{1'b0, 4'h2, 4'h2, 32'h00001300, 1'b1, 1'b1, 8'h13, 1'b1, 2'd1, 4'h2};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[14] = '{1'b0, 4'h8, 4'h0, 32'h40000000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[15] = '{1'b0, 4'h8, 4'h0, 32'h40000000, 1'b1, 1'b1, 8'h40, 1'b0, 2'd3, 4'h8};
        tbl[16] = '{1'b1, 4'h8, 4'h0, 32'h41000000, 1'b1, 1'b1, 8'h41, 1'b0, 2'd3, 4'h8};
        tbl[17] = '{1'b0, 4'h8, 4'h0, 32'h41000000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[18] = '{1'b0, 4'h8, 4'h0, 32'h41000000, 1'b1, 1'b1, 8'h41, 1'b0, 2'd3, 4'h8};
        tbl[19] = '{1'b0, 4'h8, 4'h8, 32'h42000000, 1'b1, 1'b1, 8'h42, 1'b1, 2'd3, 4'h8};
        tbl[20] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[21] = '{1'b0, 4'h2, 4'h0, 32'h00005000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};
        tbl[22] = '{1'b0, 4'h2, 4'h0, 32'h00005000, 1'b1, 1'b1, 8'h50, 1'b0, 2'd1, 4'h2};
        tbl[23] = '{1'b0, 4'h0, 4'h0, 32'h00005000, 1'b1, 1'b0, 8'h50, 1'b0, 2'd1, 4'h2};
        tbl[24] = '{1'b0, 4'h2, 4'h2, 32'h00005100, 1'b1, 1'b1, 8'h51, 1'b1, 2'd1, 4'h2};
        tbl[25] = '{1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'h0};

        clear_inputs();
        rst = 1'b1;
        cyc();

        // Strict priority with shaping off, mid-frame reset, tvalid stall.
        for (int i = 0; i < 26; i++) begin
            rst           = tbl[i].rst;
            s_axis_tvalid = tbl[i].tv;
            s_axis_tlast  = tbl[i].tl;
            s_axis_tdata  = tbl[i].td;
            m_axis_tready = tbl[i].mr;
            settle();
            chk($sformatf("tbl%0d_mvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_mdata", i),  64'(m_axis_tdata),  64'(tbl[i].ed));
            chk($sformatf("tbl%0d_mlast", i),  64'(m_axis_tlast),  64'(tbl[i].el));
            chk($sformatf("tbl%0d_muser", i),  64'(m_axis_tuser),  64'(tbl[i].eu));
            chk($sformatf("tbl%0d_sready", i), 64'(s_axis_tready), 64'(tbl[i].esr));
            cyc();
        end
        rst = 1'b0;

        // Reset state and stats.
        do_reset();
        settle();
        chk("rst_credit", 64'(credit), 64'd0);
        chk("rst_frame_cnt_lo", frame_cnt[63:0], 64'd0);
        chk("rst_frame_cnt_hi", frame_cnt[127:64], 64'd0);
        repeat (3) send_frame(0, 2);
        repeat (2) send_frame(2, 3);
`ifdef CBS_STATS_EN
        exp_cnt = '{32'd3, 32'd0, 32'd2, 32'd0};
`else
        exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("frame_cnt%0d", c), 64'(frame_cnt[c*32 +: 32]), 64'(exp_cnt[c]));
        end

        // Credit gating: class 3 drops to -12, recovers +1/cycle while class 0 is served.
        do_reset();
        cbs_en = 4'b1000;
        idle_slope[3*SW +: SW] = 16'd1;
        send_slope[3*SW +: SW] = 16'd3;
        hi_credit[3*CW +: CW]  = '0;
        s_axis_tvalid = 4'b1000;
        settle();
        chk("gate_idle_valid", 64'(m_axis_tvalid), 64'd0);
        cyc();
        for (int b = 0; b < 4; b++) begin
            s_axis_tlast = (b == 3) ? 4'b1000 : 4'b0000;
            settle();
            chk($sformatf("gate_c3_b%0d_user", b), 64'(m_axis_tuser), 64'd3);
            cyc();
        end
        s_axis_tlast  = '0;
        s_axis_tvalid = 4'b1001;
        for (int f = 0; f < 4; f++) begin
            settle();
            chk($sformatf("gate_cred_f%0d", f), 64'(cr(3)), 64'(-12 + 3 * f));
            chk($sformatf("gate_bubble_f%0d", f), 64'(m_axis_tvalid), 64'd0);
            cyc();
            s_axis_tlast = 4'b0000;
            settle();
            chk($sformatf("gate_c0_f%0d_user", f), 64'(m_axis_tuser), 64'd0);
            cyc();
            s_axis_tlast = 4'b0001;
            settle();
            chk($sformatf("gate_c0_f%0d_last", f), 64'(m_axis_tlast), 64'd1);
            cyc();
            s_axis_tlast = 4'b0000;
        end
        settle();
        chk("gate_cred_zero", 64'(cr(3)), 64'd0);
        cyc();
        settle();
        chk("gate_c3_again_user", 64'(m_axis_tuser), 64'd3);
        chk("gate_c3_again_valid", 64'(m_axis_tvalid), 64'd1);

        // hi_credit clamp: class 2 accrues behind a class-3 frame, then clears once idle.
        do_reset();
        cbs_en = 4'b0100;
        idle_slope[2*SW +: SW] = 16'd5;
        send_slope[2*SW +: SW] = 16'd2;
        hi_credit[2*CW +: CW]  = 24'd8;
        s_axis_tvalid = 4'b1100;
        settle();
        chk("clamp_cred_t0", 64'(cr(2)), 64'd0);
        cyc();
        for (int b = 0; b < 4; b++) begin
            s_axis_tlast = (b == 3) ? 4'b1000 : 4'b0000;
            settle();
            chk($sformatf("clamp_cred_b%0d", b), 64'(cr(2)), (b == 0) ? 64'd5 : 64'd8);
            chk($sformatf("clamp_c3_b%0d_user", b), 64'(m_axis_tuser), 64'd3);
            cyc();
        end
        s_axis_tvalid = 4'b0100;
        s_axis_tlast  = 4'b0000;
        settle();
        chk("clamp_cred_idle", 64'(cr(2)), 64'd8);
        cyc();
        s_axis_tlast = 4'b0100;
        settle();
        chk("clamp_c2_user", 64'(m_axis_tuser), 64'd2);
        chk("clamp_c2_last", 64'(m_axis_tlast), 64'd1);
        cyc();
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        settle();
        chk("clamp_cred_after_send", 64'(cr(2)), 64'd6);
        cyc();
        settle();
        chk("clamp_cred_cleared", 64'(cr(2)), 64'd0);

        // Backpressure: tready toggles, bytes advance and credit drops only on handshakes.
        do_reset();
        cbs_en = 4'b0010;
        send_slope[1*SW +: SW] = 16'd1;
        s_axis_tvalid = 4'b0010;
        m_axis_tready = 1'b0;
        settle();
        cyc();
        idx = 0;
        k = 0;
        while (idx < 4 && k < 16) begin
            s_axis_tdata  = {16'h0, 8'(8'hA0 + idx), 8'h0};
            s_axis_tlast  = (idx == 3) ? 4'b0010 : 4'b0000;
            m_axis_tready = k[0];
            settle();
            chk($sformatf("bp_k%0d_valid", k), 64'(m_axis_tvalid), 64'd1);
            chk($sformatf("bp_k%0d_data", k), 64'(m_axis_tdata), 64'(8'hA0 + idx));
            chk($sformatf("bp_k%0d_user", k), 64'(m_axis_tuser), 64'd1);
            chk($sformatf("bp_k%0d_sready", k), 64'(s_axis_tready), k[0] ? 64'd2 : 64'd0);
            chk($sformatf("bp_k%0d_cred", k), 64'(cr(1)), 64'(-idx));
            cyc();
            if (k[0]) idx++;
            k++;
        end
        chk("bp_bytes_done", 64'(idx), 64'd4);
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        settle();
        chk("bp_back_idle", 64'(m_axis_tvalid), 64'd0);
        chk("bp_final_cred", 64'(cr(1)), -64'sd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
